// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V controller: FSM states,
// opcodes, immediate-format selects and ALU operation codes.
package riscv_pkg;

    typedef enum logic [3:0] {
        ST_RESET    = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEMADR   = 4'd3,
        ST_MEMREAD  = 4'd4,
        ST_MEMWB    = 4'd5,
        ST_MEMWRITE = 4'd6,
        ST_EXECUTER = 4'd7,
        ST_EXECUTEI = 4'd8,
        ST_ALUWB    = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JAL      = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse aluop plus instruction fields to an ALU operation.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op[5]=1) can request sub; addi ignores bit 30.
                    3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM controller for a multicycle RV32I subset (lw, sw, R/I ALU, beq/bne, jal).
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] immsrc,
    output logic [2:0] alucontrol,
    output logic       illegal_instr
);

    state_t     state_reg;
    state_t     state_next;
    logic       pcupdate;
    logic       branch;
    logic [1:0] aluop;
    logic       memwrite_dec;
    logic       irwrite_dec;
    logic       regwrite_dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RESET;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RESET:    state_next = ST_FETCH;
            ST_FETCH:    state_next = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = ST_MEMADR;
                    OP_RTYPE:     state_next = ST_EXECUTER;
                    OP_ITYPE:     state_next = ST_EXECUTEI;
                    OP_BRANCH:    state_next = ST_BRANCH;
                    OP_JAL:       state_next = ST_JAL;
                    default:      state_next = ST_FETCH;
                endcase
            end
            ST_MEMADR:   state_next = (op == OP_LW) ? ST_MEMREAD : ST_MEMWRITE;
            ST_MEMREAD:  state_next = ST_MEMWB;
            ST_MEMWB:    state_next = ST_FETCH;
            ST_MEMWRITE: state_next = ST_FETCH;
            ST_EXECUTER: state_next = ST_ALUWB;
            ST_EXECUTEI: state_next = ST_ALUWB;
            ST_JAL:      state_next = ST_ALUWB;
            ST_ALUWB:    state_next = ST_FETCH;
            ST_BRANCH:   state_next = ST_FETCH;
            default:     state_next = ST_RESET;
        endcase
    end

    always_comb begin
        pcupdate      = 1'b0;
        branch        = 1'b0;
        aluop         = ALUOP_ADD;
        adrsrc        = 1'b0;
        memwrite_dec  = 1'b0;
        irwrite_dec   = 1'b0;
        regwrite_dec  = 1'b0;
        resultsrc     = 2'b00;
        alusrca       = 2'b00;
        alusrcb       = 2'b00;
        illegal_instr = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                irwrite_dec = 1'b1;
                alusrcb     = 2'b10;
                resultsrc   = 2'b10;
                pcupdate    = 1'b1;
            end
            ST_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                illegal_instr = !(op inside {OP_LW, OP_SW, OP_RTYPE, OP_ITYPE,
                                             OP_BRANCH, OP_JAL});
            end
            ST_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
            end
            ST_MEMREAD:  adrsrc = 1'b1;
            ST_MEMWB: begin
                resultsrc    = 2'b01;
                regwrite_dec = 1'b1;
            end
            ST_MEMWRITE: begin
                adrsrc       = 1'b1;
                memwrite_dec = 1'b1;
            end
            ST_EXECUTER: begin
                alusrca = 2'b10;
                aluop   = ALUOP_FUNCT;
            end
            ST_EXECUTEI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = ALUOP_FUNCT;
            end
            ST_ALUWB:    regwrite_dec = 1'b1;
            ST_BRANCH: begin
                alusrca = 2'b10;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
            end
            ST_JAL: begin
                alusrca  = 2'b01;
                alusrcb  = 2'b10;
                pcupdate = 1'b1;
            end
            default: ;
        endcase
    end

    // funct3[0] flips the branch sense so one state serves both beq and bne.
    assign pcwrite  = rst_n & (pcupdate | (branch & (zero ^ funct3[0])));
    assign memwrite = rst_n & memwrite_dec;
    assign irwrite  = rst_n & irwrite_dec;
    assign regwrite = rst_n & regwrite_dec;

    always_comb begin
        case (op)
            OP_LW, OP_ITYPE: immsrc = IMM_I;
            OP_SW:           immsrc = IMM_S;
            OP_BRANCH:       immsrc = IMM_B;
            OP_JAL:          immsrc = IMM_J;
            default:         immsrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench: each instruction class is modelled as a
// list of per-cycle datapath control words compared against the controller.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       pcwrite, adrsrc, memwrite, irwrite, regwrite;
    logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
    logic [2:0] alucontrol;
    logic       illegal_instr;

    int checks = 0;
    int failures = 0;

    typedef enum int {C_LW, C_SW, C_R, C_I, C_BR, C_JAL, C_ILL} cls_t;

    multicycle_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op            (op),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .pcwrite       (pcwrite),
        .adrsrc        (adrsrc),
        .memwrite      (memwrite),
        .irwrite       (irwrite),
        .regwrite      (regwrite),
        .resultsrc     (resultsrc),
        .alusrca       (alusrca),
        .alusrcb       (alusrcb),
        .immsrc        (immsrc),
        .alucontrol    (alucontrol),
        .illegal_instr (illegal_instr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [16:0] observed();
        return {pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
                alusrca, alusrcb, immsrc, alucontrol, illegal_instr};
    endfunction

    function automatic int cycles_of(cls_t c);
        case (c)
            C_LW:    return 5;
            C_BR:    return 3;
            C_ILL:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [6:0] opcode_of(cls_t c);
        case (c)
            C_LW:    return 7'b0000011;
            C_SW:    return 7'b0100011;
            C_R:     return 7'b0110011;
            C_I:     return 7'b0010011;
            C_BR:    return 7'b1100011;
            C_JAL:   return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [1:0] imm_of(logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    // ALU operation an arithmetic instruction asks for.
    function automatic logic [2:0] arith_op(bit is_r, logic [2:0] f3, logic f7);
        case (f3)
            3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected control word for cycle p of an instruction of class c (p<0: reset).
    function automatic logic [16:0] expected(cls_t c, int p, logic [6:0] o,
                                             logic [2:0] f3, logic f7, logic z);
        logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
        logic [1:0] rs = 0, sa = 0, sb = 0;
        logic [2:0] alu = 3'b000;
        if (p == 0) begin
            irw = 1; sb = 2'b10; rs = 2'b10; pcw = 1;
        end else if (p == 1) begin
            sa = 2'b01; sb = 2'b01; ill = (c == C_ILL);
        end else if (p >= 2) begin
            case (c)
                C_LW, C_SW: begin
                    if (p == 2) begin sa = 2'b10; sb = 2'b01; end
                    else if (c == C_SW) begin adr = 1; mw = 1; end
                    else if (p == 3) adr = 1;
                    else begin rs = 2'b01; rw = 1; end
                end
                C_R, C_I, C_JAL: begin
                    if (p == 3) rw = 1;
                    else if (c == C_JAL) begin sa = 2'b01; sb = 2'b10; pcw = 1; end
                    else begin
                        sa = 2'b10;
                        sb = (c == C_I) ? 2'b01 : 2'b00;
                        alu = arith_op(c == C_R, f3, f7);
                    end
                end
                C_BR: begin
                    sa = 2'b10; alu = 3'b001;
                    pcw = f3[0] ? !z : z;
                end
                default: ;
            endcase
        end
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm_of(o), alu, ill};
    endfunction

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("reset_release", {15'd0, observed()},
                 {15'd0, expected(C_ILL, -1, op, funct3, funct7b5, zero)});
    endtask

    // zmode <0 randomizes zero every cycle; abort_p >=0 drops reset after that cycle.
    task automatic run_instr(input cls_t c, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input int zmode, input int abort_p);
        for (int p = 0; p < cycles_of(c); p++) begin
            @(posedge clk);
            #1;
            if (p == 0) begin
                op = o; funct3 = f3; funct7b5 = f7;
            end
            zero = (zmode < 0) ? 1'($urandom) : 1'(zmode);
            @(negedge clk);
            check_eq($sformatf("%s op=%b f3=%b z=%b cyc%0d", c.name(), o, f3, zero, p),
                     {15'd0, observed()},
                     {15'd0, expected(c, p, o, f3, f7, zero)});
            if (p == abort_p) begin
                rst_n = 1'b0;
                #1;
                check_eq("abort_memwrite", {31'd0, memwrite}, 32'd0);
                check_eq("abort_word", {15'd0, observed()},
                         {15'd0, expected(c, -1, o, f3, f7, zero)});
                @(posedge clk);
                #1;
                check_eq("abort_hold", {15'd0, observed()},
                         {15'd0, expected(c, -1, o, f3, f7, zero)});
                release_reset();
                return;
            end
        end
    endtask

    initial begin
        cls_t       c;
        logic [6:0] o;
        @(negedge clk);
        @(negedge clk);
        check_eq("in_reset", {15'd0, observed()}, 32'd0);
        release_reset();

        // Directed cases
        run_instr(C_LW, 7'b0000011, 3'b010, 1'b0, -1, -1);
        run_instr(C_SW, 7'b0100011, 3'b010, 1'b0, -1, -1);
        run_instr(C_BR, 7'b1100011, 3'b000, 1'b0, 1, -1);
        run_instr(C_BR, 7'b1100011, 3'b000, 1'b0, 0, -1);
        run_instr(C_BR, 7'b1100011, 3'b001, 1'b0, 0, -1);
        run_instr(C_BR, 7'b1100011, 3'b001, 1'b0, 1, -1);
        run_instr(C_R,  7'b0110011, 3'b000, 1'b1, -1, -1);
        run_instr(C_I,  7'b0010011, 3'b000, 1'b1, -1, -1);
        run_instr(C_ILL, 7'b0000000, 3'b000, 1'b0, -1, -1);
        run_instr(C_JAL, 7'b1101111, 3'b000, 1'b0, -1, -1);
        run_instr(C_SW, 7'b0100011, 3'b000, 1'b0, -1, 3);

        // Random instruction stream
        for (int n = 0; n < 300; n++) begin
            c = cls_t'($urandom_range(0, 6));
            o = opcode_of(c);
            if (c == C_ILL) begin
                o = 7'($urandom);
                while (o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                 7'b1100011, 7'b1101111})
                    o = 7'($urandom);
            end
            run_instr(c, o, 3'($urandom), 1'($urandom), -1,
                      ($urandom_range(0, 40) == 0) ? $urandom_range(0, cycles_of(c) - 1) : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
